// File: rtl/pump_soft_start.sv
// Per-pump duty conditioner: soft-start ramp on increases, immediate decreases,
// and a latched dry-run interlock that forces the pump off until cleared.
module pump_soft_start #(
  parameter int TICK_CYCLES = 250_000,
  parameter int STEP_SIZE   = 4,
  parameter int DRY_TICKS   = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] duty_target,
  input  logic       dry_sense,
  input  logic       fault_clear,
  output logic [7:0] duty_out,
  output logic       ramping,
  output logic       fault
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DW = $clog2(DRY_TICKS + 1);

  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_CYCLES - 1);
  localparam logic [DW-1:0] DRY_MAX = DW'(DRY_TICKS);
  localparam logic [8:0]    STEP9   = 9'(STEP_SIZE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RAMP  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] FAULT = 2'd3;

  logic [1:0]    state;
  logic [1:0]    state_next;
  logic [7:0]    duty_next;
  logic [PW-1:0] pre_cnt;
  logic [DW-1:0] dry_cnt;
  logic [DW-1:0] dry_next;
  logic          tick;
  logic          dry_trip;
  logic [8:0]    ramp_sum;
  logic [7:0]    ramp_duty;

  assign tick     = (pre_cnt == PRE_MAX);
  assign dry_trip = (dry_cnt == DRY_MAX);

  // Nine-bit sum so a step near full scale clamps to the target instead of wrapping.
  assign ramp_sum  = {1'b0, duty_out} + STEP9;
  assign ramp_duty = (ramp_sum > {1'b0, duty_target}) ? duty_target : ramp_sum[7:0];

  always_comb begin
    state_next = state;
    duty_next  = duty_out;
    if (state == FAULT) begin
      duty_next = 8'd0;
      if (fault_clear && !dry_sense) begin
        state_next = IDLE;
      end
    end else if (dry_trip) begin
      state_next = FAULT;
      duty_next  = 8'd0;
    end else if (!enable) begin
      state_next = IDLE;
      duty_next  = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          duty_next = 8'd0;
          if (duty_target != 8'd0) begin
            state_next = RAMP;
          end
        end
        RAMP: begin
          if (duty_target < duty_out) begin
            duty_next  = duty_target;
            state_next = (duty_target == 8'd0) ? IDLE : HOLD;
          end else if (tick) begin
            duty_next = ramp_duty;
            if (ramp_duty == duty_target) begin
              state_next = HOLD;
            end
          end
        end
        HOLD: begin
          if (duty_target > duty_out) begin
            state_next = RAMP;
          end else if (duty_target < duty_out) begin
            duty_next  = duty_target;
            state_next = (duty_target == 8'd0) ? IDLE : HOLD;
          end
        end
        default: begin
          state_next = IDLE;
          duty_next  = 8'd0;
        end
      endcase
    end
  end

  // Dry time only accumulates while actually driving into a dry sump.
  always_comb begin
    dry_next = dry_cnt;
    if (!dry_sense || duty_out == 8'd0) begin
      dry_next = '0;
    end else if (tick && !dry_trip) begin
      dry_next = dry_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      duty_out <= 8'd0;
      ramping  <= 1'b0;
      fault    <= 1'b0;
      pre_cnt  <= '0;
      dry_cnt  <= '0;
    end else begin
      state    <= state_next;
      duty_out <= duty_next;
      ramping  <= (state_next == RAMP);
      fault    <= (state_next == FAULT);
      pre_cnt  <= tick ? '0 : pre_cnt + PW'(1);
      dry_cnt  <= dry_next;
    end
  end

endmodule

// File: tb/tb_pump_soft_start.sv
// Scoreboard bench for pump_soft_start: stimulus queues expected outputs by cycle,
// a monitor compares them on the falling edge or on demand for async reset.
module tb_pump_soft_start;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [7:0] duty_target = 8'd0;
  logic       dry_sense = 1'b0;
  logic       fault_clear = 1'b0;
  logic [7:0] duty_out;
  logic       ramping;
  logic       fault;

  typedef struct {
    string      name;
    int         due;
    bit         imm;
    logic [7:0] duty;
    logic       ramp;
    logic       flt;
  } exp_t;

  exp_t expQ[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  event asyncCheck;

  pump_soft_start #(
    .TICK_CYCLES(TICK),
    .STEP_SIZE(4),
    .DRY_TICKS(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .duty_target(duty_target),
    .dry_sense(dry_sense),
    .fault_clear(fault_clear),
    .duty_out(duty_out),
    .ramping(ramping),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Bench-side cycle count tracks the prescaler phase: tick edges land on multiples of TICK.
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (duty_out !== e.duty || ramping !== e.ramp || fault !== e.flt) begin
      miscompares++;
      $display("[TB] FAIL %s: got duty=%0d ramping=%b fault=%b, expected duty=%0d ramping=%b fault=%b",
               e.name, duty_out, ramping, fault, e.duty, e.ramp, e.flt);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk or asyncCheck);
      while (expQ.size() > 0 && (expQ[0].imm || expQ[0].due <= cyc)) begin
        e = expQ.pop_front();
        if (!e.imm && e.due < cyc) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL %s: sampled late at cycle %0d, expected at cycle %0d", e.name, cyc, e.due);
        end else begin
          checkOutput(e);
        end
      end
    end
  end

  task automatic applyStimulus(input logic en, input logic [7:0] tgt, input logic dry, input logic clr);
    enable      = en;
    duty_target = tgt;
    dry_sense   = dry;
    fault_clear = clr;
  endtask

  task automatic expectAt(input string name, input int due, input logic [7:0] d, input logic r, input logic f);
    exp_t e;
    e.name = name; e.due = due; e.imm = 1'b0; e.duty = d; e.ramp = r; e.flt = f;
    expQ.push_back(e);
  endtask

  task automatic expectNow(input string name, input logic [7:0] d, input logic r, input logic f);
    exp_t e;
    e.name = name; e.due = cyc; e.imm = 1'b1; e.duty = d; e.ramp = r; e.flt = f;
    expQ.push_back(e);
    -> asyncCheck;
  endtask

  task automatic waitNeg();
    @(negedge clk);
    #1;
  endtask

  task automatic waitUntil(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      waitNeg();
      guard++;
    end
  endtask

  function automatic int tickAfter(input int n);
    return (n / TICK + 1) * TICK;
  endfunction

  initial begin
    int c;
    int c2;
    int t;

    applyStimulus(1'b0, 8'd0, 1'b0, 1'b0);
    #3;
    expectNow("reset_state", 8'd0, 1'b0, 1'b0);
    waitNeg();
    waitNeg();
    reset = 1'b1;
    expectAt("idle_after_reset", 1, 8'd0, 1'b0, 1'b0);
    waitNeg();

    // Soft start 0 -> 10
    c = cyc;
    applyStimulus(1'b1, 8'd10, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("ramp_enter", c + 1, 8'd0, 1'b1, 1'b0);
    expectAt("ramp_wait_tick", t - 1, 8'd0, 1'b1, 1'b0);
    expectAt("ramp_step4", t, 8'd4, 1'b1, 1'b0);
    expectAt("ramp_step8", t + 4, 8'd8, 1'b1, 1'b0);
    expectAt("ramp_hold10", t + 8, 8'd10, 1'b0, 1'b0);
    waitUntil(t + 8);

    c = cyc;
    applyStimulus(1'b1, 8'd100, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("hold_to_ramp", c + 1, 8'd10, 1'b1, 1'b0);
    expectAt("climb_98", t + 84, 8'd98, 1'b1, 1'b0);
    expectAt("climb_100", t + 88, 8'd100, 1'b0, 1'b0);
    waitUntil(t + 88);

    // Immediate decreases
    c = cyc;
    applyStimulus(1'b1, 8'd20, 1'b0, 1'b0);
    expectAt("decrease_20", c + 1, 8'd20, 1'b0, 1'b0);
    waitNeg();
    c = cyc;
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    expectAt("decrease_0", c + 1, 8'd0, 1'b0, 1'b0);
    waitNeg();
    waitNeg();

    // Saturation near full scale
    c = cyc;
    applyStimulus(1'b1, 8'd250, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("to250_enter", c + 1, 8'd0, 1'b1, 1'b0);
    expectAt("to250_hold", t + 248, 8'd250, 1'b0, 1'b0);
    waitUntil(t + 248);
    c = cyc;
    applyStimulus(1'b1, 8'd255, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("sat_enter", c + 1, 8'd250, 1'b1, 1'b0);
    expectAt("sat_254", t, 8'd254, 1'b1, 1'b0);
    expectAt("sat_255", t + 4, 8'd255, 1'b0, 1'b0);
    expectAt("sat_stay", t + 8, 8'd255, 1'b0, 1'b0);
    waitUntil(t + 8);

    // Enable drop mid-ramp
    c = cyc;
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    expectAt("to_idle", c + 1, 8'd0, 1'b0, 1'b0);
    waitNeg();
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("ramp40_4", t, 8'd4, 1'b1, 1'b0);
    expectAt("ramp40_8", t + 4, 8'd8, 1'b1, 1'b0);
    waitUntil(t + 4);
    c = cyc;
    applyStimulus(1'b0, 8'd40, 1'b0, 1'b0);
    expectAt("enable_drop", c + 1, 8'd0, 1'b0, 1'b0);
    expectAt("disabled_idle", c + 5, 8'd0, 1'b0, 1'b0);
    waitUntil(c + 5);
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("reenable", c + 1, 8'd0, 1'b1, 1'b0);
    expectAt("reenable_4", t, 8'd4, 1'b1, 1'b0);
    expectAt("reenable_40", t + 36, 8'd40, 1'b0, 1'b0);
    waitUntil(t + 36);

    // Dry-run trip, ignored clear, then recovery
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
    t = tickAfter(c);
    expectAt("dry_pre_trip", t + 8, 8'd40, 1'b0, 1'b0);
    expectAt("dry_trip", t + 9, 8'd0, 1'b0, 1'b1);
    waitUntil(t + 9);
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b1);
    expectAt("clear_while_dry", c + 2, 8'd0, 1'b0, 1'b1);
    waitNeg();
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
    waitUntil(c + 2);
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    expectAt("fault_wet", c + 1, 8'd0, 1'b0, 1'b1);
    waitNeg();
    c2 = cyc;
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b1);
    t = tickAfter(c2 + 2);
    expectAt("fault_cleared", c2 + 1, 8'd0, 1'b0, 1'b0);
    expectAt("restart_ramp", c2 + 2, 8'd0, 1'b1, 1'b0);
    expectAt("restart_4", t, 8'd4, 1'b1, 1'b0);
    expectAt("restart_8", t + 4, 8'd8, 1'b1, 1'b0);
    expectAt("restart_40", t + 36, 8'd40, 1'b0, 1'b0);
    waitNeg();
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    waitUntil(t + 36);

    // Two dry ticks, one wet cycle, two dry ticks: counter must restart
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
    t = tickAfter(c);
    expectAt("gap_no_trip", t + 9, 8'd40, 1'b0, 1'b0);
    expectAt("gap_still_hold", t + 13, 8'd40, 1'b0, 1'b0);
    waitUntil(t + 4);
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    waitNeg();
    applyStimulus(1'b1, 8'd40, 1'b1, 1'b0);
    waitUntil(t + 12);
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    waitUntil(t + 13);

    // Async reset mid-ramp at duty 12
    c = cyc;
    applyStimulus(1'b1, 8'd0, 1'b0, 1'b0);
    expectAt("idle_again", c + 1, 8'd0, 1'b0, 1'b0);
    waitNeg();
    c = cyc;
    applyStimulus(1'b1, 8'd40, 1'b0, 1'b0);
    t = tickAfter(c + 1);
    expectAt("ramp_12", t + 8, 8'd12, 1'b1, 1'b0);
    waitUntil(t + 8);
    #2;
    reset = 1'b0;
    #1;
    expectNow("async_reset_ramp", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd8, 1'b0, 1'b0);
    waitNeg();
    reset = 1'b1;
    expectAt("post_reset_ramp", 1, 8'd0, 1'b1, 1'b0);
    expectAt("post_reset_4", 4, 8'd4, 1'b1, 1'b0);
    expectAt("post_reset_8", 8, 8'd8, 1'b0, 1'b0);
    waitUntil(8);

    // Async reset while faulted
    c = cyc;
    applyStimulus(1'b1, 8'd8, 1'b1, 1'b0);
    t = tickAfter(c);
    expectAt("fault_again", t + 9, 8'd0, 1'b0, 1'b1);
    waitUntil(t + 9);
    #2;
    reset = 1'b0;
    #1;
    expectNow("async_reset_fault", 8'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'd8, 1'b0, 1'b0);
    waitNeg();
    reset = 1'b1;
    expectAt("fault_not_kept", 1, 8'd0, 1'b1, 1'b0);
    waitUntil(3);

    if (expQ.size() != 0) begin
      miscompares += expQ.size();
      $display("[TB] FAIL pending_expectations: got %0d unchecked entries, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
